saida_serial_uc: RTL
====================

Name: saida_serial_uc

Overview:
- Control unit for the serial output datapath. Sequences one 4-character frame: hundreds digit, tens digit, units digit, then '#'.
- Drives the datapath's character-select counter (zera/conta) and the per-character transmit start (proximo). Consumes the counter's fim_contador and the transmitter's serial_pronto.
- Adds a one-deep pending-request latch and a per-character watchdog, so that a stuck transmitter cannot hang the system.

Parameters:
- TIMEOUT_CICLOS, 10000: cycles allowed in ESPERA for serial_pronto before the error state; must be ≥ 2.
- TIMEOUT_BITS, 14: width of the watchdog counter; 2^TIMEOUT_BITS ≥ TIMEOUT_CICLOS.

Ports:
- clock  in  1  system clock, all state on the rising edge.
- reset  in  1  asynchronous, active-low reset. Low forces INICIAL immediately.
- partida  in  1  frame request, sampled each cycle. Level or pulse.
- fim_contador  in  1  datapath counter is at its last character (Q=3, '#').
- serial_pronto  in  1  transmitter finished the current character.
- zera_contador  out  1  synchronous clear of the datapath character counter.
- conta_contador  out  1  advance the datapath character counter.
- proximo  out  1  one-cycle start pulse to the transmitter.
- pronto  out  1  one-cycle pulse when the frame is complete.
- ocupado  out  1  high in every state except INICIAL and ERRO.
- erro  out  1  high while in ERRO.
- db_estado  out  4  current state encoding, for debug.

Behaviour:
- Moore outputs, decoded from the state register only.
- Reset values: all outputs 0; db_estado=0; pendente=0; watchdog=0.
- State encodings: INICIAL=0, PREPARA=1, TRANSMITE=2, ESPERA=3, PROXIMO=4, FINAL=5, ERRO=4'hE. Unused codes go to INICIAL.
- INICIAL:
  - partida=1 → PREPARA; otherwise stay.
- PREPARA:
  - zera_contador=1.
  - Always → TRANSMITE.
- TRANSMITE:
  - proximo=1 for exactly one cycle.
  - Clears the watchdog.
  - Always → ESPERA.
- ESPERA:
  - Watchdog increments each cycle.
  - serial_pronto=1 and fim_contador=0 → PROXIMO.
  - serial_pronto=1 and fim_contador=1 → FINAL.
  - serial_pronto=0 and watchdog=TIMEOUT_CICLOS-1 → ERRO.
  - serial_pronto takes priority over timeout in the same cycle.
- PROXIMO:
  - conta_contador=1. The counter advances on this edge, so the next TRANSMITE sees the new character.
  - Always → TRANSMITE.
- FINAL:
  - pronto=1.
  - pendente=1 or partida=1 → PREPARA, and pendente clears.
  - Otherwise → INICIAL.
- ERRO:
  - erro=1, sticky.
  - partida=1 → PREPARA, and pendente clears.
  - The frame restarts from the hundreds digit.
- Pending-request latch:
  - partida=1 in PREPARA/TRANSMITE/ESPERA/PROXIMO sets pendente.
  - Only one request is remembered; extra requests are dropped.
  - partida held high continuously causes back-to-back frames.
- Fixed frame timing: partida sampled at edge t gives PREPARA at t+1, first proximo at t+2.
- Full frame: exactly 4 proximo pulses and 3 conta_contador pulses, then one pronto pulse.
- Reset asserted mid-frame: immediate return to INICIAL with all outputs 0. No pronto is issued.

Decomposition:
- Shared package holds the state encoding constants (the 4-bit codes above) for reuse by the debug display decoder.
- The watchdog is one instance of the team's existing contador_m (M=TIMEOUT_CICLOS, N=TIMEOUT_BITS):
  - zera_s driven by TRANSMITE;
  - conta driven by ESPERA;
  - its fim output is the timeout condition.
- The FSM itself stays in this module.

Test Plan:
- Normal frame: bench uses TIMEOUT_CICLOS=16 and a transmitter model returning serial_pronto 5 cycles after each proximo; dados=12'h357. → Exactly 4 proximo pulses, 3 conta_contador pulses, and pronto one cycle after the 4th serial_pronto. The datapath emits '3','5','7','#'.
- Pending request: partida pulsed while in ESPERA of the 2nd character. → FINAL goes directly to PREPARA, a second 4-character frame follows, and pendente is 0 at the end.
- Timeout: serial_pronto never returned. → ERRO (db_estado=E, erro=1) exactly 16 cycles after the proximo pulse. Then pulse partida → PREPARA, erro=0, and the counter is cleared.
- Priority in the same cycle: serial_pronto=1 on watchdog count 15. → PROXIMO (or FINAL), no ERRO.
- Reset mid-frame: drive reset low during ESPERA of the 3rd character. → db_estado=0 and all outputs 0 without waiting for a clock edge. No pronto. The next partida starts a full 4-character frame.
- Continuous partida held at 1 for 3 frames. → pronto pulses exactly 3 times, each followed by PREPARA with no INICIAL cycle in between.

Source files
------------

// File: rtl/saida_serial_uc_pkg.sv
// Shared definitions for the serial output control unit: state codes are also
// consumed by the debug display decoder, so their values are fixed here.
package saida_serial_uc_pkg;

   typedef enum logic [3:0] {
      INICIAL   = 4'h0,
      PREPARA   = 4'h1,
      TRANSMITE = 4'h2,
      ESPERA    = 4'h3,
      PROXIMO   = 4'h4,
      FINAL     = 4'h5,
      ERRO      = 4'hE
   } estado_t;

   localparam int unsigned CARACTERES_POR_QUADRO = 4;

   // Busy covers the whole frame including the completion state.
   function automatic logic estado_ocupado(input estado_t e);
      return (e != INICIAL) && (e != ERRO);
   endfunction

   // States in which a new frame request must be remembered for later.
   function automatic logic estado_memoriza(input estado_t e);
      return (e == PREPARA) || (e == TRANSMITE) || (e == ESPERA) || (e == PROXIMO);
   endfunction

endpackage

// File: rtl/saida_serial_uc_contador_m.sv
// Modulo-M counter with synchronous clear and enable; fim flags the last count.
module contador_m #(
   parameter int M = 16,
   parameter int N = 4
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         zera_s,
   input  logic         conta,
   output logic [N-1:0] Q,
   output logic         fim
);

   localparam logic [N-1:0] ULTIMO = N'(M - 1);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         Q <= '0;
      end else if (zera_s) begin
         Q <= '0;
      end else if (conta) begin
         if (Q == ULTIMO) begin
            Q <= '0;
         end else begin
            Q <= Q + N'(1);
         end
      end
   end

   assign fim = (Q == ULTIMO);

endmodule

// File: rtl/saida_serial_uc.sv
// Control unit for the serial output datapath: sends hundreds, tens, units and
// '#', with a one-deep pending request and a per-character watchdog.
module saida_serial_uc
   import saida_serial_uc_pkg::*;
#(
   parameter int TIMEOUT_CICLOS = 10000,
   parameter int TIMEOUT_BITS   = 14
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       partida,
   input  logic       fim_contador,
   input  logic       serial_pronto,
   output logic       zera_contador,
   output logic       conta_contador,
   output logic       proximo,
   output logic       pronto,
   output logic       ocupado,
   output logic       erro,
   output logic [3:0] db_estado
);

   estado_t                 estado;
   estado_t                 proximo_estado;
   logic                    pendente;
   logic                    timeout;
   logic [TIMEOUT_BITS-1:0] watchdog_q_unused;

   // The watchdog restarts on every character start and only counts while waiting.
   contador_m #(
      .M(TIMEOUT_CICLOS),
      .N(TIMEOUT_BITS)
   ) u_watchdog (
      .clock  (clock),
      .reset  (reset),
      .zera_s (estado == TRANSMITE),
      .conta  (estado == ESPERA),
      .Q      (watchdog_q_unused),
      .fim    (timeout)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado   <= INICIAL;
         pendente <= 1'b0;
      end else begin
         estado <= proximo_estado;
         if ((estado == FINAL) || ((estado == ERRO) && partida)) begin
            pendente <= 1'b0;
         end else if (partida && estado_memoriza(estado)) begin
            pendente <= 1'b1;
         end
      end
   end

   always_comb begin
      proximo_estado = estado;
      case (estado)
         INICIAL:   if (partida) proximo_estado = PREPARA;
         PREPARA:   proximo_estado = TRANSMITE;
         TRANSMITE: proximo_estado = ESPERA;
         ESPERA: begin
            // A completed character wins over a timeout on the same cycle.
            if (serial_pronto) begin
               proximo_estado = fim_contador ? FINAL : PROXIMO;
            end else if (timeout) begin
               proximo_estado = ERRO;
            end
         end
         PROXIMO:   proximo_estado = TRANSMITE;
         FINAL:     proximo_estado = (pendente || partida) ? PREPARA : INICIAL;
         ERRO:      if (partida) proximo_estado = PREPARA;
         default:   proximo_estado = INICIAL;
      endcase
   end

   always_comb begin
      zera_contador  = 1'b0;
      conta_contador = 1'b0;
      proximo        = 1'b0;
      pronto         = 1'b0;
      erro           = 1'b0;
      ocupado        = estado_ocupado(estado);
      db_estado      = estado;
      case (estado)
         PREPARA:   zera_contador  = 1'b1;
         TRANSMITE: proximo        = 1'b1;
         PROXIMO:   conta_contador = 1'b1;
         FINAL:     pronto         = 1'b1;
         ERRO:      erro           = 1'b1;
         default:   ;
      endcase
   end

endmodule
